// File: rtl/row_fetcher.sv
// row_fetcher: maps a destination row to a source row, burst-loads it into a line buffer,
// then serves pixels by destination column through the horizontal scale factor.
module row_fetcher #(
  parameter int PIX_WIDTH = 16,
  parameter int FIX_LEN   = 15,
  parameter int FLOAT_LEN = 11,
  parameter int SRC_H_NUM = 640,
  parameter int SRC_V_NUM = 360,
  localparam int RW = $clog2(SRC_V_NUM),
  localparam int CW = $clog2(SRC_H_NUM)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wr_req,
  input  logic [10:0]          dst_row,
  input  logic [FIX_LEN-1:0]   x_scale,
  input  logic [FIX_LEN-1:0]   y_scale,
  input  logic [10:0]          x_pos,
  output logic                 tran_done,
  output logic [PIX_WIDTH-1:0] input_data,
  output logic                 rd_req,
  output logic [RW-1:0]        rd_row,
  input  logic                 rd_ack,
  input  logic [PIX_WIDTH-1:0] rd_data,
  input  logic                 rd_data_vld
);
  localparam int PW = 11 + FIX_LEN;
  typedef enum logic [2:0] {IDLE, CALC, REQ, LOAD, DONE, RELEASE} state_t;
  state_t state_q, state_d;
  logic [10:0] dst_m1, x_m1;
  logic [PW-1:0] y_sh, x_sh;
  logic [RW-1:0] src_row_d, src_row_q, last_row_q;
  logic [CW-1:0] src_col_d, col_q, wr_addr_q;
  logic row_valid_q, hit, load_wr, load_end;
  logic [PIX_WIDTH-1:0] input_data_q;
  logic [PIX_WIDTH-1:0] line_buf [SRC_H_NUM];
  assign dst_m1    = (dst_row == '0) ? '0 : dst_row - 11'd1;
  assign x_m1      = (x_pos == '0) ? '0 : x_pos - 11'd1;
  assign y_sh      = (PW'(dst_m1) * PW'(y_scale)) >> FLOAT_LEN;
  assign x_sh      = (PW'(x_m1) * PW'(x_scale)) >> FLOAT_LEN;
  assign src_row_d = (y_sh > PW'(SRC_V_NUM - 1)) ? RW'(SRC_V_NUM - 1) : y_sh[RW-1:0];
  assign src_col_d = (x_sh > PW'(SRC_H_NUM - 1)) ? CW'(SRC_H_NUM - 1) : x_sh[CW-1:0];
  assign hit       = row_valid_q && (last_row_q == src_row_q);
  assign load_wr   = (state_q == LOAD) && rd_data_vld;
  assign load_end  = load_wr && (wr_addr_q == CW'(SRC_H_NUM - 1));
  assign tran_done = (state_q == DONE);
  assign rd_req    = (state_q == REQ);
  assign rd_row    = src_row_q;
  assign input_data = input_data_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = wr_req ? CALC : IDLE;
      CALC:    state_d = hit ? DONE : REQ;
      REQ:     state_d = rd_ack ? LOAD : REQ;
      LOAD:    state_d = load_end ? DONE : LOAD;
      DONE:    state_d = RELEASE;
      RELEASE: state_d = wr_req ? RELEASE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      src_row_q    <= '0;
      last_row_q   <= '0;
      row_valid_q  <= 1'b0;
      wr_addr_q    <= '0;
      col_q        <= '0;
      input_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && wr_req) src_row_q <= src_row_d;
      if (state_q == REQ && rd_ack) begin
        row_valid_q <= 1'b0;
        wr_addr_q   <= '0;
      end
      if (load_wr) wr_addr_q <= wr_addr_q + 1'b1;
      if (load_end) begin
        last_row_q  <= src_row_q;
        row_valid_q <= 1'b1;
      end
      col_q        <= src_col_d;
      input_data_q <= line_buf[col_q];
    end
  end
  // Line buffer has no reset; its contents are only meaningful after a completed load.
  always_ff @(posedge clk) begin
    if (load_wr) line_buf[wr_addr_q] <= rd_data;
  end
endmodule

// File: doc/row_fetcher.md
# row_fetcher

Source-row supplier for the scaler's per-row output generator. It answers each row request with the matching source row:
- it maps the destination row to a source row through the vertical scale factor;
- it burst-reads that row from the frame-buffer read port into an internal line buffer, then pulses `tran_done`;
- during the output pass it returns source pixels addressed by the generator's `x_pos`, mapped through the horizontal scale factor.

## Interface
- `PIX_WIDTH`, 16: pixel width in bits.
- `FIX_LEN`, 15: total width of the scale factors.
- `FLOAT_LEN`, 11: fractional bits of the scale factors (format 4.11).
- `SRC_H_NUM`, 640: source pixels per row; also the line-buffer depth.
- `SRC_V_NUM`, 360: source rows per frame.

Ports:
- `clk` in 1: single clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `wr_req` in 1: row request. Level signal, held high until the cycle after `tran_done`.
- `dst_row` in 11: destination row, 1-based. Stable while `wr_req` is high.
- `x_scale` in 15: horizontal source/destination ratio, unsigned 4.11.
- `y_scale` in 15: vertical source/destination ratio, unsigned 4.11.
- `x_pos` in 11: destination column, 1-based, driven by the generator each cycle.
- `tran_done` out 1: one-cycle pulse; the line buffer holds the requested row.
- `input_data` out 16: source pixel for `x_pos` presented 2 cycles earlier.
- `rd_req` out 1: frame-buffer row read request, held until `rd_ack`.
- `rd_row` out 9: source row number to read, valid while `rd_req` is high.
- `rd_ack` in 1: read request accepted (one-cycle handshake).
- `rd_data` in 16: burst pixel data.
- `rd_data_vld` in 1: `rd_data` valid. Exactly one pixel per asserted cycle.

## Operation
Row mapping, computed from `dst_row` when the request is sampled in IDLE:
- `src_row = ((dst_row-1) * y_scale) >> FLOAT_LEN`.
- `dst_row` of 0 is treated as 1.
- Product width is 26 bits.
- The result is clamped to `SRC_V_NUM-1`.

Column mapping:
- `src_col = ((x_pos-1) * x_scale) >> FLOAT_LEN`.
- `x_pos` of 0 is treated as 1.
- The result is clamped to `SRC_H_NUM-1`.

Cache: the block keeps `last_row` and a `row_valid` flag.
- A request whose `src_row` equals `last_row` while `row_valid` is set is a hit. No read is issued.
- `row_valid` is cleared by reset.
- `row_valid` is cleared on entry to LOAD.
- `row_valid` is set on completion of LOAD.

State machine:
- IDLE: when `wr_req` is high, register `src_row` and go to CALC.
- CALC: on a hit go to DONE; on a miss go to REQ.
- REQ: `rd_req` is high and `rd_row = src_row`. When `rd_ack` is high, go to LOAD.
- LOAD: each `rd_data_vld` writes `rd_data` to the line buffer at `wr_addr`, then increments `wr_addr`, starting from 0.
  - After the `SRC_H_NUM`-th write, set `last_row`, set `row_valid`, and go to DONE.
  - `rd_data_vld` seen outside LOAD is ignored.
- DONE: `tran_done` is high for exactly one cycle. Go to RELEASE.
- RELEASE: wait for `wr_req` low, then go to IDLE. This prevents retriggering on the held request level.

Read path:
- Runs in every state, including during LOAD.
- Stage 1 registers `src_col`.
- Stage 2 registers the line-buffer read into `input_data`.
- During LOAD, reads return the partially written buffer. The output is defined only after `tran_done`.

Reset:
- Reset at any point, including mid-LOAD, returns the FSM to IDLE and clears `row_valid` and `wr_addr`.
- Line-buffer contents are undefined after reset.

## Timing
- Reset values: `tran_done` 0, `rd_req` 0, `rd_row` 0, `input_data` 0.
- Let `wr_req` be sampled high in IDLE at cycle 0. CALC is at cycle 1.
- Hit: `tran_done` is high at cycle 2.
- Miss: `rd_req` rises at cycle 2.
- From `rd_ack` at cycle A, LOAD begins at A+1.
- The last valid word at cycle L gives `tran_done` at L+1.
- `rd_req` drops in the cycle after `rd_ack`.
- Pixel latency: `x_pos` at cycle k gives `input_data` at k+2. The generator's `data_vaild` is delayed by 2 to match.
- A new request cannot start before `wr_req` has been observed low for at least 1 cycle after DONE.

## Test plan
- Unity scale:
  - Stimulus: `x_scale = y_scale = 0x0800`, `dst_row = 5`; memory returns `pixel = row*1024+col`.
  - Required: `rd_row = 4`, 640 words loaded, `tran_done` 1 cycle after the last word.
  - Required: `x_pos` 1..640 gives `input_data` 4096..4735, each 2 cycles later.
- Cache hit:
  - Stimulus: `y_scale = 0x0400` (2x upscale); request `dst_row` 3, then `dst_row` 4.
  - Required: both map to `src_row` 1. The second request has no `rd_req`, and `tran_done` comes 2 cycles after sampling.
- Downscale clamp:
  - Stimulus: `y_scale = 0x1000`, `dst_row = 200`.
  - Required: `rd_row = 359`.
  - Stimulus: `x_scale = 0x1000`, `x_pos = 400`.
  - Required: `src_col = 639`.
- Delayed accept with gapped burst:
  - Stimulus: `rd_ack` 7 cycles late; `rd_data_vld` toggles every other cycle.
  - Required: `rd_req` stays high until `rd_ack`; exactly 640 writes; a stray `rd_data_vld` after DONE does not corrupt the buffer.
- Reset mid-LOAD:
  - Stimulus: assert `rstn` low after 100 words.
  - Required: outputs are 0 immediately; the next request for the same row misses and reloads all 640 words.
- Held request:
  - Stimulus: keep `wr_req` high for 5 cycles after `tran_done`.
  - Required: a single `tran_done` pulse; FSM in RELEASE until `wr_req` falls.
